// File: rtl/text_pkg.sv
// Shared constants, FSM state type and character classification for the morse text buffer.
package text_pkg;

    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN   = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        CLEAR_ROW
    } state_t;

    function automatic logic isPrintable(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character storage: single write port, registered read port, no reset so it maps onto block RAM.
module text_ram #(
    parameter int DEPTH = 120,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Read-before-write: a same-cycle read of the written cell returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/morse_text_buffer.sv
// Character screen buffer fed by a morse decoder; define TEXT_SCROLL_EN to scroll on bottom-row overflow
// instead of wrapping the cursor back to the top-left cell.
module morse_text_buffer
    import text_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic                    clear,
    input  logic [$clog2(COLS)-1:0] rd_col,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [7:0]              rd_char,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [CW-1:0] cursorCol_q;
    logic [RW-1:0] cursorRow_q;
    logic [RW-1:0] topPtr_q;
    logic          charReady_q;
    logic          wrEn_q;
    logic [AW-1:0] wrAddr_q;
    logic [7:0]    wrData_q;
    logic          rdOob_q;

    logic          lastRow;
    logic          advScroll;
    logic [RW-1:0] advRow_d;
    logic [RW-1:0] advTop_d;
    logic [CW-1:0] bsCol;
    logic [RW-1:0] bsRow;
    logic [AW-1:0] curAddr;
    logic [AW-1:0] bsAddr;
    logic [AW-1:0] rowBase;
    logic          rdInRange;
    logic [AW-1:0] ramRdAddr;
    logic [7:0]    ramRdData;

    function automatic logic [RW-1:0] physRow(input logic [RW-1:0] top, input logic [RW-1:0] row);
        logic [RW:0] s;
        s = {1'b0, top} + {1'b0, row};
        if (s >= (RW+1)'(ROWS)) begin
            s = s - (RW+1)'(ROWS);
        end
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cellAddr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(prow * COLS + col);
    endfunction

    always_comb begin
        lastRow   = (cursorRow_q == RW'(ROWS-1));
        advRow_d  = cursorRow_q + 1'b1;
        advTop_d  = topPtr_q;
        advScroll = 1'b0;
        if (lastRow) begin
`ifdef TEXT_SCROLL_EN
            advRow_d  = cursorRow_q;
            advTop_d  = (topPtr_q == RW'(ROWS-1)) ? '0 : topPtr_q + 1'b1;
            advScroll = 1'b1;
`else
            advRow_d  = '0;
`endif
        end
        bsCol     = (cursorCol_q == '0) ? CW'(COLS-1) : cursorCol_q - 1'b1;
        bsRow     = (cursorCol_q == '0) ? cursorRow_q - 1'b1 : cursorRow_q;
        curAddr   = cellAddr(physRow(topPtr_q, cursorRow_q), cursorCol_q);
        bsAddr    = cellAddr(physRow(topPtr_q, bsRow), bsCol);
        rowBase   = cellAddr(physRow(topPtr_q, RW'(ROWS-1)), '0);
        rdInRange = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
        ramRdAddr = rdInRange ? cellAddr(physRow(topPtr_q, rd_row), rd_col) : '0;
    end

    // Writes are staged one cycle in wr*_q, so a character lands in RAM on the edge after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR_ALL;
            cnt_q       <= '0;
            cursorCol_q <= '0;
            cursorRow_q <= '0;
            topPtr_q    <= '0;
            charReady_q <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= CLEAR_CHAR;
        end else begin
            wrEn_q <= 1'b0;
            if (clear) begin
                state_q     <= CLEAR_ALL;
                cnt_q       <= '0;
                cursorCol_q <= '0;
                cursorRow_q <= '0;
                topPtr_q    <= '0;
                charReady_q <= 1'b0;
            end else begin
                case (state_q)
                    CLEAR_ALL: begin
                        wrEn_q   <= 1'b1;
                        wrAddr_q <= cnt_q;
                        wrData_q <= CLEAR_CHAR;
                        if (cnt_q == AW'(DEPTH-1)) begin
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                            charReady_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`ifdef TEXT_SCROLL_EN
                    CLEAR_ROW: begin
                        wrEn_q   <= 1'b1;
                        wrAddr_q <= rowBase + cnt_q;
                        wrData_q <= CLEAR_CHAR;
                        if (cnt_q == AW'(COLS-1)) begin
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                            charReady_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
`endif
                    IDLE: begin
                        if (char_valid) begin
                            if (isPrintable(char_in) || char_in == ASCII_NL) begin
                                if (isPrintable(char_in)) begin
                                    wrEn_q   <= 1'b1;
                                    wrAddr_q <= curAddr;
                                    wrData_q <= char_in;
                                end
                                if (char_in == ASCII_NL || cursorCol_q == CW'(COLS-1)) begin
                                    cursorCol_q <= '0;
                                    cursorRow_q <= advRow_d;
                                    topPtr_q    <= advTop_d;
                                    if (advScroll) begin
                                        state_q     <= CLEAR_ROW;
                                        cnt_q       <= '0;
                                        charReady_q <= 1'b0;
                                    end
                                end else begin
                                    cursorCol_q <= cursorCol_q + 1'b1;
                                end
                            end else if (char_in == ASCII_BS) begin
                                if (cursorCol_q != '0 || cursorRow_q != '0) begin
                                    cursorCol_q <= bsCol;
                                    cursorRow_q <= bsRow;
                                    wrEn_q      <= 1'b1;
                                    wrAddr_q    <= bsAddr;
                                    wrData_q    <= CLEAR_CHAR;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        charReady_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Out-of-range flag travels with the read data; forcing it at reset makes rd_char read blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdOob_q <= 1'b1;
        end else begin
            rdOob_q <= !rdInRange;
        end
    end

    text_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wrEn_q),
        .waddr (wrAddr_q),
        .wdata (wrData_q),
        .raddr (ramRdAddr),
        .rdata (ramRdData)
    );

    assign rd_char    = rdOob_q ? CLEAR_CHAR : ramRdData;
    assign char_ready = charReady_q;
    assign cursor_col = cursorCol_q;
    assign cursor_row = cursorRow_q;

endmodule

// File: tb/tb_morse_text_buffer.sv
// Directed self-checking bench for morse_text_buffer with a 4x3 screen.
module tb_morse_text_buffer;

   localparam int COLS = 4;
   localparam int ROWS = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] charIn;
   logic       charValid;
   logic       charReady;
   logic       clear;
   logic [1:0] rdCol;
   logic [1:0] rdRow;
   logic [7:0] rdChar;
   logic [1:0] cursorCol;
   logic [1:0] cursorRow;

   int compared   = 0;
   int mismatched = 0;

   morse_text_buffer #(
      .COLS       (COLS),
      .ROWS       (ROWS),
      .CLEAR_CHAR (8'h20)
   ) dut (
      .clk        (clock),
      .reset      (reset),
      .char_in    (charIn),
      .char_valid (charValid),
      .char_ready (charReady),
      .clear      (clear),
      .rd_col     (rdCol),
      .rd_row     (rdRow),
      .rd_char    (rdChar),
      .cursor_col (cursorCol),
      .cursor_row (cursorRow)
   );

   // 100 MHz clock
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one character for a single cycle
   task automatic applyStimulus(input logic [7:0] c);
      charIn    = c;
      charValid = 1'b1;
      tick();
      charValid = 1'b0;
      charIn    = 8'h00;
   endtask

   // Two edges so any staged write has reached the RAM before the read is captured
   task automatic checkCell(input string tag, input int r, input int c, input logic [7:0] exp);
      rdRow = 2'(r);
      rdCol = 2'(c);
      tick();
      tick();
      checkOutput(tag, {24'h0, rdChar}, {24'h0, exp});
   endtask

   task automatic checkCursor(input string tag, input int r, input int c);
      checkOutput({tag, "_row"}, {30'h0, cursorRow}, r);
      checkOutput({tag, "_col"}, {30'h0, cursorCol}, c);
   endtask

   // Bounded wait for char_ready; returns the number of cycles it stayed low
   task automatic waitReady(output int n);
      n = 0;
      while (!charReady && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic doClear();
      int n;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      waitReady(n);
      checkOutput("clear_cycles", n, 12);
   endtask

   initial begin
      int     n;
      string  s;
      reset     = 1'b1;
      charIn    = 8'h00;
      charValid = 1'b0;
      clear     = 1'b0;
      rdRow     = 2'd0;
      rdCol     = 2'd0;
      repeat (3) tick();

      // Reset values
      checkOutput("rst_ready", {31'h0, charReady}, 0);
      checkOutput("rst_rdchar", {24'h0, rdChar}, 32'h20);
      checkCursor("rst_cursor", 0, 0);

      // Initial full-screen clear takes one cycle per cell
      reset = 1'b0;
      waitReady(n);
      checkOutput("init_cycles", n, 12);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            checkCell($sformatf("init_r%0dc%0d", r, c), r, c, 8'h20);
         end
      end
      checkCell("oob_row", 3, 0, 8'h20);

      // "ABCDE" wraps onto the second row
      s = "ABCDE";
      for (int i = 0; i < 5; i++) applyStimulus(s[i]);
      for (int c = 0; c < 4; c++) checkCell($sformatf("abcde_r0c%0d", c), 0, c, s[c]);
      checkCell("abcde_r1c0", 1, 0, "E");
      checkCell("abcde_r1c1", 1, 1, 8'h20);
      checkCursor("abcde_cursor", 1, 1);
      checkCell("oob_after_write", 3, 1, 8'h20);

      // Non-printable code is swallowed, newline moves to next row
      applyStimulus(8'h01);
      checkCursor("ctrl_cursor", 1, 1);
      checkCell("ctrl_r1c1", 1, 1, 8'h20);
      applyStimulus(8'h0A);
      checkCursor("nl_cursor", 2, 0);
      checkCell("nl_r2c0", 2, 0, 8'h20);

      // Clear beats a simultaneous character; input while not ready is dropped
      clear     = 1'b1;
      charValid = 1'b1;
      charIn    = "Q";
      tick();
      clear     = 1'b0;
      charValid = 1'b0;
      checkOutput("clrq_ready", {31'h0, charReady}, 0);
      checkCursor("clrq_cursor", 0, 0);
      applyStimulus("X");
      waitReady(n);
      checkOutput("clrq_cycles", n, 11);
      checkCursor("clrq_after", 0, 0);
      checkCell("clrq_r2c0", 2, 0, 8'h20);
      checkCell("clrq_r0c0", 0, 0, 8'h20);

      // Backspace steps back and blanks, stops at the origin
      applyStimulus("A");
      applyStimulus("B");
      applyStimulus(8'h08);
      checkCursor("bs1_cursor", 0, 1);
      applyStimulus(8'h08);
      applyStimulus(8'h08);
      checkCursor("bs3_cursor", 0, 0);
      for (int c = 0; c < 4; c++) checkCell($sformatf("bs_r0c%0d", c), 0, c, 8'h20);

      // Backspace from column 0 wraps to the end of the previous row
      s = "ABCD";
      for (int i = 0; i < 4; i++) applyStimulus(s[i]);
      checkCursor("bswrap_pre", 1, 0);
      applyStimulus(8'h08);
      checkCursor("bswrap_cursor", 0, 3);
      checkCell("bswrap_r0c3", 0, 3, 8'h20);
      checkCell("bswrap_r0c2", 0, 2, "C");

      // Reset in the middle of a clear restarts the full clear
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkCursor("midrst_cursor", 0, 0);
      waitReady(n);
      checkOutput("midrst_cycles", n, 12);
      checkCell("midrst_r0c2", 0, 2, 8'h20);

      doClear();
      s = "abcdefghijkl";
`ifdef TEXT_SCROLL_EN
      // Overflowing the bottom row scrolls and blanks the new bottom row
      for (int i = 0; i < 12; i++) applyStimulus(s[i]);
      checkOutput("scroll_ready", {31'h0, charReady}, 0);
      checkCursor("scroll_cursor", 2, 0);
      waitReady(n);
      checkOutput("scroll_cycles", n, 4);
      applyStimulus("Z");
      for (int c = 0; c < 4; c++) checkCell($sformatf("scroll_r0c%0d", c), 0, c, s[4+c]);
      for (int c = 0; c < 4; c++) checkCell($sformatf("scroll_r1c%0d", c), 1, c, s[8+c]);
      checkCell("scroll_r2c0", 2, 0, "Z");
      checkCell("scroll_r2c1", 2, 1, 8'h20);
      checkCell("scroll_r2c3", 2, 3, 8'h20);
      checkCursor("scroll_z_cursor", 2, 1);
`else
      // Without scrolling the cursor wraps to the origin and overwrites
      for (int i = 0; i < 12; i++) begin
         applyStimulus(s[i]);
         checkOutput($sformatf("wrap_ready_%0d", i), {31'h0, charReady}, 1);
      end
      checkCursor("wrap_cursor", 0, 0);
      applyStimulus("Z");
      checkOutput("wrap_ready_z", {31'h0, charReady}, 1);
      checkCursor("wrap_z_cursor", 0, 1);
      checkCell("wrap_r0c0", 0, 0, "Z");
      checkCell("wrap_r0c1", 0, 1, "b");
      checkCell("wrap_r2c3", 2, 3, "l");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
